// File: rtl/uart_tx_cfg_if.sv
// Request/line bundle between a system-clock master and the configurable UART transmitter.
// The master drives the request and word; the transmitter drives status, strobes and the serial line.
interface uart_tx_cfg_if #(
    parameter int DATA_W = 8
);
    logic              i_tx_start;
    logic [DATA_W-1:0] i_data;
    logic              o_tx_ready;
    logic              o_rs232_txd;
    logic              o_baudrate_tx_clk_en;
    logic              o_tx_done;
    logic              o_tx_busy;

    modport master (
        output i_tx_start,
        output i_data,
        input  o_tx_ready,
        input  o_rs232_txd,
        input  o_baudrate_tx_clk_en,
        input  o_tx_done,
        input  o_tx_busy
    );

    modport slave (
        input  i_tx_start,
        input  i_data,
        output o_tx_ready,
        output o_rs232_txd,
        output o_baudrate_tx_clk_en,
        output o_tx_done,
        output o_tx_busy
    );
endinterface

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter with built-in baud divider: start, DATA_W bits LSB first,
// optional odd/even parity, 1 or 2 stop bits. One word per accepted request.
module uart_tx_cfg #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115_200,
    parameter int DATA_W    = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_tx_cfg_if.slave  tx
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] BAUD_PRE  = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_W - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
    localparam bit               HAS_PARITY = (PARITY != 0);

    if (CLKS_PER_BIT < 2) begin : g_chk_baud
        $error("uart_tx_cfg: CLK_FREQ/BAUD must be at least 2");
    end
    if (DATA_W < 5 || DATA_W > 9) begin : g_chk_data_w
        $error("uart_tx_cfg: DATA_W must be within 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_chk_parity
        $error("uart_tx_cfg: PARITY must be 0 (none), 1 (odd) or 2 (even)");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e            state_q;
    logic [DATA_W-1:0] shift_q;
    logic              parity_q;
    logic [3:0]        bit_cnt_q;
    logic [CNT_W-1:0]  baud_cnt_q;
    logic              txd_q;
    logic              ready_q;
    logic              busy_q;
    logic              baud_en_q;
    logic              done_q;
    logic              baud_last;

    assign baud_last = (baud_cnt_q == BAUD_LAST);

    // NOTE: all state lives in this one clocked block and is written only with <=, so every
    // read below sees the value from before the edge regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            bit_cnt_q  <= '0;
            baud_cnt_q <= '0;
            txd_q      <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            baud_en_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            baud_en_q <= 1'b0;

            // Strobe is registered one cycle early so it lands on the last cycle of each bit.
            if (state_q != S_IDLE) begin
                baud_cnt_q <= baud_last ? '0 : baud_cnt_q + 1'b1;
                if (baud_cnt_q == BAUD_PRE) begin
                    baud_en_q <= 1'b1;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (tx.i_tx_start) begin
                        shift_q    <= tx.i_data;
                        parity_q   <= (PARITY == 2) ? (^tx.i_data) : (~^tx.i_data);
                        baud_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        txd_q      <= 1'b0;
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_START;
                    end
                end

                S_START: begin
                    if (baud_last) begin
                        txd_q   <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        state_q <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (baud_last) begin
                        if (bit_cnt_q == DATA_LAST) begin
                            bit_cnt_q <= '0;
                            if (HAS_PARITY) begin
                                txd_q   <= parity_q;
                                state_q <= S_PARITY;
                            end else begin
                                txd_q   <= 1'b1;
                                state_q <= S_STOP;
                            end
                        end else begin
                            txd_q     <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end

                S_PARITY: begin
                    if (baud_last) begin
                        txd_q     <= 1'b1;
                        bit_cnt_q <= '0;
                        state_q   <= S_STOP;
                    end
                end

                S_STOP: begin
                    if (baud_last) begin
                        if (bit_cnt_q == STOP_LAST) begin
                            bit_cnt_q <= '0;
                            ready_q   <= 1'b1;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= S_IDLE;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx.o_tx_ready           = ready_q;
    assign tx.o_rs232_txd          = txd_q;
    assign tx.o_baudrate_tx_clk_en = baud_en_q;
    assign tx.o_tx_done            = done_q;
    assign tx.o_tx_busy            = busy_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: four configurations (8N1, 8E1, 8O1, 7N2) at 10 clocks per bit,
// a frame table plus hand-written back-to-back, mid-frame reset and ignored-request sequences.
module tb_uart_tx_cfg;

    localparam int C = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] start = '0;
    logic [8:0] data [4];
    wire  [3:0] txd, rdy, ben, done, busy;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int dw  [4] = '{8, 8, 8, 7};
    int par [4] = '{0, 2, 1, 0};
    int nsb [4] = '{1, 1, 1, 2};
    int fb  [4] = '{10, 11, 11, 10};

    uart_tx_cfg_if #(.DATA_W(8)) if0 ();
    uart_tx_cfg_if #(.DATA_W(8)) if1 ();
    uart_tx_cfg_if #(.DATA_W(8)) if2 ();
    uart_tx_cfg_if #(.DATA_W(7)) if3 ();

    assign if0.i_tx_start = start[0];
    assign if1.i_tx_start = start[1];
    assign if2.i_tx_start = start[2];
    assign if3.i_tx_start = start[3];
    assign if0.i_data = data[0][7:0];
    assign if1.i_data = data[1][7:0];
    assign if2.i_data = data[2][7:0];
    assign if3.i_data = data[3][6:0];

    assign txd  = {if3.o_rs232_txd, if2.o_rs232_txd, if1.o_rs232_txd, if0.o_rs232_txd};
    assign rdy  = {if3.o_tx_ready, if2.o_tx_ready, if1.o_tx_ready, if0.o_tx_ready};
    assign ben  = {if3.o_baudrate_tx_clk_en, if2.o_baudrate_tx_clk_en,
                   if1.o_baudrate_tx_clk_en, if0.o_baudrate_tx_clk_en};
    assign done = {if3.o_tx_done, if2.o_tx_done, if1.o_tx_done, if0.o_tx_done};
    assign busy = {if3.o_tx_busy, if2.o_tx_busy, if1.o_tx_busy, if0.o_tx_busy};

    uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_W(8), .PARITY(0), .STOP_BITS(1))
        u_8n1 (.clk(clk), .rst_n(rst_n), .tx(if0));
    uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_W(8), .PARITY(2), .STOP_BITS(1))
        u_8e1 (.clk(clk), .rst_n(rst_n), .tx(if1));
    uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_W(8), .PARITY(1), .STOP_BITS(1))
        u_8o1 (.clk(clk), .rst_n(rst_n), .tx(if2));
    uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_W(7), .PARITY(0), .STOP_BITS(2))
        u_7n2 (.clk(clk), .rst_n(rst_n), .tx(if3));

    int errors = 0;
    int checks = 0;
    int last_done_cyc = 0;
    logic sb [$];

    typedef struct {
        int         dut;
        logic [8:0] word;
        int         exp_par;   // expected parity bit on the line, -1 when there is none
        int         exp_done;  // cycle offset of the done pulse after the accept cycle
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference frame: start, data LSB first, parity from a ones count, stop bits.
    function automatic void push_frame(input int d, input logic [8:0] w);
        int ones = 0;
        sb.push_back(1'b0);
        for (int i = 0; i < dw[d]; i++) begin
            sb.push_back(w[i]);
            ones += int'(w[i]);
        end
        if (par[d] == 2) sb.push_back(ones % 2 == 1);
        else if (par[d] == 1) sb.push_back(ones % 2 == 0);
        for (int i = 0; i < nsb[d]; i++) sb.push_back(1'b1);
    endfunction

    task automatic check_idle(input int d, input string tag);
        check({tag, "_txd"},   txd[d],  1);
        check({tag, "_ready"}, rdy[d],  1);
        check({tag, "_busy"},  busy[d], 0);
        check({tag, "_baud"},  ben[d],  0);
        check({tag, "_done"},  done[d], 0);
    endtask

    task automatic accept(input int d, input logic [8:0] w);
        @(negedge clk);
        check("ready_before_accept", rdy[d], 1);
        start[d] = 1'b1;
        data[d]  = w;
        push_frame(d, w);
        @(posedge clk);
    endtask

    // Follows one frame cycle by cycle from accept+1 to the done cycle (or a planted reset).
    task automatic watch(input int d, input int exp_done, input int exp_par, input bit keep_start,
                         input logic [8:0] next_word, input int inject_at, input int reset_at);
        int   nj = fb[d] * C + 1;
        int   done_j = -1, done_cnt = 0, strobes = 0;
        int   hold_err = 0, ben_err = 0, busy_err = 0;
        logic exp_bit = 1'b1;
        for (int j = 1; j <= nj; j++) begin
            @(negedge clk);
            if (reset_at > 0 && j == reset_at + 1) begin
                check_idle(d, "after_reset");
                rst_n = 1'b1;
                sb.delete();
                return;
            end
            if (j < nj) begin
                if ((j - 1) % C == 0) begin
                    exp_bit = sb.pop_front();
                    check($sformatf("dut%0d_txd_bit%0d", d, (j - 1) / C), txd[d], exp_bit);
                end else if (txd[d] !== exp_bit) begin
                    hold_err++;
                end
                if (busy[d] !== 1'b1 || rdy[d] !== 1'b0) busy_err++;
                if (ben[d] !== (j % C == 0)) ben_err++;
            end else begin
                check("done_cycle_txd",   txd[d],  1);
                check("done_cycle_ready", rdy[d],  1);
                check("done_cycle_busy",  busy[d], 0);
            end
            if (ben[d] === 1'b1) strobes++;
            if (done[d] === 1'b1) begin
                done_cnt++;
                if (done_j < 0) done_j = j;
                last_done_cyc = cyc;
            end
            if (exp_par >= 0 && j == (1 + dw[d]) * C + 1) check("parity_bit", txd[d], exp_par);
            if (j == 1) begin
                if (keep_start) data[d] = next_word;
                else start[d] = 1'b0;
            end
            if (inject_at > 0 && j == inject_at) begin
                start[d] = 1'b1;
                data[d]  = 9'h1FF;
            end
            if (inject_at > 0 && j == inject_at + 1) start[d] = 1'b0;
            if (reset_at > 0 && j == reset_at) rst_n = 1'b0;
        end
        check("done_offset",   done_j,   exp_done);
        check("done_count",    done_cnt, 1);
        check("baud_strobes",  strobes,  fb[d]);
        check("baud_position", ben_err,  0);
        check("txd_hold",      hold_err, 0);
        check("busy_ready",    busy_err, 0);
        check("sb_empty",      sb.size(), 0);
    endtask

    task automatic idle_window(input int d, input int n, input string tag);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done[d] !== 1'b0 || busy[d] !== 1'b0 || txd[d] !== 1'b1 || rdy[d] !== 1'b1) bad++;
        end
        check(tag, bad, 0);
    endtask

    initial begin
        int t_first;
        for (int d = 0; d < 4; d++) data[d] = '0;

        vecs[0] = '{0, 9'h0A5, -1, 101};
        vecs[1] = '{1, 9'h007,  1, 111};
        vecs[2] = '{2, 9'h007,  0, 111};
        vecs[3] = '{3, 9'h055, -1, 101};
        vecs[4] = '{0, 9'h0FF, -1, 101};
        vecs[5] = '{1, 9'h0FF,  0, 111};
        vecs[6] = '{2, 9'h080,  0, 111};
        vecs[7] = '{3, 9'h07F, -1, 101};

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 4; d++) check_idle(d, $sformatf("reset_dut%0d", d));
        rst_n = 1'b1;

        for (int v = 0; v < 8; v++) begin
            accept(vecs[v].dut, vecs[v].word);
            watch(vecs[v].dut, vecs[v].exp_done, vecs[v].exp_par, 1'b0, '0, -1, -1);
            idle_window(vecs[v].dut, 3, "idle_after_frame");
        end

        // Back-to-back: request held high, second word accepted in the done cycle.
        accept(0, 9'h000);
        watch(0, 101, -1, 1'b1, 9'h0FF, -1, -1);
        t_first = last_done_cyc;
        push_frame(0, 9'h0FF);
        @(posedge clk);
        watch(0, 101, -1, 1'b0, '0, -1, -1);
        check("done_gap", last_done_cyc - t_first, fb[0] * C + 1);
        idle_window(0, 3, "idle_after_b2b");

        // Reset mid-DATA aborts the frame without a done pulse; the next frame is clean.
        accept(0, 9'h000);
        watch(0, 101, -1, 1'b0, '0, -1, 35);
        idle_window(0, 10, "no_done_after_reset");
        accept(0, 9'h03C);
        watch(0, 101, -1, 1'b0, '0, -1, -1);
        idle_window(0, 3, "idle_after_3c");

        // A request while busy is dropped, not queued.
        accept(0, 9'h000);
        watch(0, 101, -1, 1'b0, '0, 50, -1);
        idle_window(0, 20, "busy_request_ignored");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
